// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one 32-bit word per line.
// A hit answers the fetcher in one cycle. A miss issues one read to the
// memory controller and fills the line when the word comes back. `clear`
// stops delivery to the fetcher, but a read already issued still fills the line.
// Optional feature macro: ICACHE_PERF_EN adds the hit_cnt/miss_cnt counter ports.
// Handshake: fetch_req is a level held until ins_valid or clear. ins_valid is a
// one-cycle pulse. ic_flag is high for exactly one rdy=1 cycle per issued read.
// ins_addr is stable from the ic_flag rise until ins_rdy.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    input  logic        ic_enable,
    input  logic        ins_rdy,
    input  logic [31:0] ins,
    output logic        ic_flag,
    output logic [31:0] ins_addr
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;

    // state_q can be probed hierarchically to see where the miss sequence is
    state_t            state_q, state_d;
    logic              drop_q, drop_d;
    logic              ic_flag_q, ic_flag_d;
    logic              ins_valid_q, ins_valid_d;
    logic [31:0]       ins_out_q, ins_out_d;
    logic [31:0]       ins_addr_q, ins_addr_d;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic                  fill_en;
    logic                  hit_evt;
    logic                  miss_evt;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_W-1:0]      pc_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  unused_ok;

    assign pc_index   = fetch_pc[INDEX_BITS+1:2];
    assign pc_tag     = fetch_pc[31:INDEX_BITS+2];
    assign fill_index = ins_addr_q[INDEX_BITS+1:2];
    assign fill_tag   = ins_addr_q[31:INDEX_BITS+2];
    assign hit        = valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);

    // Next-state and output logic; with rdy=0 every register holds its value
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        ic_flag_d   = ic_flag_q;
        ins_valid_d = ins_valid_q;
        ins_out_d   = ins_out_q;
        ins_addr_d  = ins_addr_q;
        fill_en     = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;
        if (rdy) begin
            ic_flag_d   = 1'b0;
            ins_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    // ins_valid_q high means this request was just answered
                    if (fetch_req && !clear && !ins_valid_q) begin
                        if (hit) begin
                            ins_out_d   = data_mem[pc_index];
                            ins_valid_d = 1'b1;
                            hit_evt     = 1'b1;
                        end else begin
                            ins_addr_d = {fetch_pc[31:2], 2'b00};
                            state_d    = MISS_REQ;
                            miss_evt   = 1'b1;
                        end
                    end
                end
                MISS_REQ: begin
                    if (clear) begin
                        state_d = IDLE;
                    end else if (ic_enable) begin
                        ic_flag_d = 1'b1;
                        drop_d    = 1'b0;
                        state_d   = MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (clear) drop_d = 1'b1;
                    if (ins_rdy) begin
                        fill_en = 1'b1;
                        if (!drop_q && !clear) begin
                            ins_out_d   = ins;
                            ins_valid_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers and valid bits with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            ic_flag_q   <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_out_q   <= '0;
            ins_addr_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            ic_flag_q   <= ic_flag_d;
            ins_valid_q <= ins_valid_d;
            ins_out_q   <= ins_out_d;
            ins_addr_q  <= ins_addr_d;
            if (fill_en) valid_q[fill_index] <= 1'b1;
        end
    end

    // Tag/data arrays need no reset because the valid bits guard them
    always_ff @(posedge clk) begin
        if (fill_en && rst) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= ins;
        end
    end

    assign ins_valid = ins_valid_q;
    assign ins_out   = ins_out_q;
    assign ic_flag   = ic_flag_q;
    assign ins_addr  = ins_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Event counters; they wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign unused_ok = ^fetch_pc[1:0];
`else
    assign unused_ok = ^{fetch_pc[1:0], hit_evt, miss_evt};
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed test of icache (hit/miss, conflict, flush, stalls, reset).
// Build with +define+ICACHE_PERF_EN to also check the counters.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic        ic_enable = 1'b1;
    logic        ins_rdy = 1'b0;
    logic [31:0] ins = '0;
    logic        ic_flag;
    logic [31:0] ins_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    icache #(.INDEX_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .fetch_req (fetch_req),
        .fetch_pc  (fetch_pc),
        .ins_valid (ins_valid),
        .ins_out   (ins_out),
        .ic_enable (ic_enable),
        .ins_rdy   (ins_rdy),
        .ins       (ins),
        .ic_flag   (ic_flag),
        .ins_addr  (ins_addr)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // Memory contents seen by the cache
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0010_0093;
            32'h0000_0050: return 32'h0050_0113;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; fetch_req = 1'b0; clear = 1'b0; ins_rdy = 1'b0;
        rdy = 1'b1; ic_enable = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Driver: holds a fetch, answers ic_flag after lat cycles, reports what it saw
    task automatic do_fetch(input logic [31:0] pc, input int lat, output logic got,
                            output logic [31:0] word, output int flags,
                            output logic [31:0] addr, output int cyc);
        int cnt;
        got = 1'b0; word = '0; flags = 0; addr = '0; cyc = 0; cnt = 0;
        fetch_pc = pc; fetch_req = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            ins_rdy = 1'b0;
            if (ins_valid) begin
                got = 1'b1; word = ins_out;
            end else if (ic_flag) begin
                flags++; addr = ins_addr; cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin ins_rdy = 1'b1; ins = mem_word(addr); end
            end
        end
        fetch_req = 1'b0; ins_rdy = 1'b0;
        @(negedge clk);
    endtask

    // Steps until ic_flag is seen; returns 0 on timeout
    task automatic wait_flag(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ic_flag) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ins_valid got %b want 0", ins_valid); end
        n_checks++; if (ic_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ic_flag got %b want 0", ic_flag); end
        n_checks++; if (ins_out !== 32'h0) begin n_fail++; $display("FAIL reset_ins_out got %h want 0", ins_out); end
        n_checks++; if (ins_addr !== 32'h0) begin n_fail++; $display("FAIL reset_ins_addr got %h want 0", ins_addr); end
    endtask

    task automatic test_cold_miss_hit();
        logic got; logic [31:0] w, a; int f, c;
        do_reset();
        do_fetch(32'h10, 2, got, w, f, a, c);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL cold_valid got %b want 1", got); end
        n_checks++; if (w !== 32'h0010_0093) begin n_fail++; $display("FAIL cold_word got %h want 00100093", w); end
        n_checks++; if (f !== 1) begin n_fail++; $display("FAIL cold_flag_cycles got %0d want 1", f); end
        n_checks++; if (a !== 32'h10) begin n_fail++; $display("FAIL cold_addr got %h want 00000010", a); end
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL cold_latency got %0d want 5", c); end
        do_fetch(32'h10, 2, got, w, f, a, c);
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL hit_latency got %0d want 1", c); end
        n_checks++; if (f !== 0) begin n_fail++; $display("FAIL hit_flag got %0d want 0", f); end
        n_checks++; if (w !== 32'h0010_0093) begin n_fail++; $display("FAIL hit_word got %h want 00100093", w); end
`ifdef ICACHE_PERF_EN
        n_checks++; if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_miss_cnt got %0d want 1", miss_cnt); end
        n_checks++; if (hit_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_hit_cnt got %0d want 1", hit_cnt); end
`endif
    endtask

    task automatic test_conflict();
        logic got; logic [31:0] w, a; int f, c;
        logic [31:0] pcs [3];
        logic [31:0] exp_w [3];
        pcs[0] = 32'h10; pcs[1] = 32'h50; pcs[2] = 32'h10;
        exp_w[0] = 32'h0010_0093; exp_w[1] = 32'h0050_0113; exp_w[2] = 32'h0010_0093;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_fetch(pcs[i], 1 + i, got, w, f, a, c);
            n_checks++; if (f !== 1) begin n_fail++; $display("FAIL conflict_flag[%0d] got %0d want 1", i, f); end
            n_checks++; if (a !== pcs[i]) begin n_fail++; $display("FAIL conflict_addr[%0d] got %h want %h", i, a, pcs[i]); end
            n_checks++; if (w !== exp_w[i]) begin n_fail++; $display("FAIL conflict_word[%0d] got %h want %h", i, w, exp_w[i]); end
        end
    endtask

    task automatic test_flush_miss_wait();
        logic seen, got; logic [31:0] w, a; int f, c, nv;
        do_reset();
        fetch_pc = 32'h24; fetch_req = 1'b1;
        wait_flag(seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL flush_flag_timeout got %b want 1", seen); end
        @(negedge clk);
        clear = 1'b1; fetch_req = 1'b0;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear = 1'b0; ins_rdy = 1'b0;
            if (ins_valid) nv++;
            if (i == 1) begin ins_rdy = 1'b1; ins = mem_word(32'h24); end
        end
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL flush_no_valid got %0d want 0", nv); end
        do_fetch(32'h24, 2, got, w, f, a, c);
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL flush_refetch_latency got %0d want 1", c); end
        n_checks++; if (w !== (32'h24 ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL flush_refetch_word got %h want %h", w, 32'h24 ^ 32'hA5A5_0000); end
        // clear arriving with a hit request suppresses the hit
        fetch_req = 1'b1; clear = 1'b1;
        @(negedge clk);
        n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hit_valid got %b want 0", ins_valid); end
        clear = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_delayed_accept();
        int nf;
        do_reset();
        ic_enable = 1'b0;
        fetch_pc = 32'h30; fetch_req = 1'b1;
        nf = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ic_flag) nf++;
        end
        n_checks++; if (nf !== 0) begin n_fail++; $display("FAIL accept_early_flag got %0d want 0", nf); end
        ic_enable = 1'b1;
        @(negedge clk);
        n_checks++; if (ic_flag !== 1'b1) begin n_fail++; $display("FAIL accept_flag_rise got %b want 1", ic_flag); end
        n_checks++; if (ins_addr !== 32'h30) begin n_fail++; $display("FAIL accept_addr got %h want 00000030", ins_addr); end
        rdy = 1'b0;
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ic_flag) nf++;
        end
        n_checks++; if (nf !== 3) begin n_fail++; $display("FAIL stall_flag_hold got %0d want 3", nf); end
        rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (ic_flag !== 1'b0) begin n_fail++; $display("FAIL stall_flag_drop got %b want 0", ic_flag); end
        ins_rdy = 1'b1; ins = mem_word(32'h30);
        @(negedge clk);
        ins_rdy = 1'b0; fetch_req = 1'b0;
        n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL accept_valid got %b want 1", ins_valid); end
        n_checks++; if (ins_out !== (32'h30 ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL accept_word got %h want %h", ins_out, 32'h30 ^ 32'hA5A5_0000); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_miss();
        logic seen, got; logic [31:0] w, a; int f, c, nv;
        do_reset();
        fetch_pc = 32'h40; fetch_req = 1'b1;
        wait_flag(seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_flag_timeout got %b want 1", seen); end
        @(negedge clk);
        rst = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ins_rdy = 1'b1; ins = mem_word(32'h40);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ins_rdy = 1'b0;
            if (ins_valid) nv++;
        end
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL rstmid_no_valid got %0d want 0", nv); end
        do_fetch(32'h40, 1, got, w, f, a, c);
        n_checks++; if (f !== 1) begin n_fail++; $display("FAIL rstmid_remiss got %0d want 1", f); end
        n_checks++; if (w !== (32'h40 ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL rstmid_word got %h want %h", w, 32'h40 ^ 32'hA5A5_0000); end
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_conflict();
        test_flush_miss_wait();
        test_delayed_accept();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
